// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU control / M-extension controller.
// Holds the ALUOp encodings, the ALU Operation code enum, the M-extension
// Funct3 codes, the Funct7 patterns and the iterative-unit FSM state enum.
package alu_ctrl_pkg;

  // ALUOp encodings from the main decoder
  localparam logic [1:0] AluOpMem    = 2'b00;  // LW/SW/AUIPC
  localparam logic [1:0] AluOpBranch = 2'b01;
  localparam logic [1:0] AluOpArith  = 2'b10;  // R/I-type
  localparam logic [1:0] AluOpJump   = 2'b11;  // JAL/LUI

  typedef enum logic [3:0] {
    OpAnd = 4'b0000,
    OpOr  = 4'b0001,
    OpAdd = 4'b0010,
    OpSub = 4'b0011,
    OpXor = 4'b0100,
    OpSrl = 4'b0101,
    OpSll = 4'b0110,
    OpSra = 4'b0111,
    OpEq  = 4'b1000,
    OpSlt = 4'b1100
  } alu_op_e;

  // M-extension Funct3 codes
  localparam logic [2:0] F3Mul    = 3'b000;
  localparam logic [2:0] F3Mulh   = 3'b001;
  localparam logic [2:0] F3Mulhsu = 3'b010;
  localparam logic [2:0] F3Mulhu  = 3'b011;
  localparam logic [2:0] F3Div    = 3'b100;
  localparam logic [2:0] F3Divu   = 3'b101;
  localparam logic [2:0] F3Rem    = 3'b110;
  localparam logic [2:0] F3Remu   = 3'b111;

  // Funct7 patterns
  localparam logic [6:0] F7Alt    = 7'b0100000;  // SUB / SRA
  localparam logic [6:0] F7MulDiv = 7'b0000001;  // M-extension

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } md_state_e;

endpackage

// File: rtl/md_iter_core.sv
// Iterative unsigned multiply / divide datapath, one bit per step.
//   clk, reset     : clock, synchronous active-high reset
//   load           : capture opa (multiplier / dividend) and opb
//   step           : advance one iteration
//   is_div         : 1 = restoring divide, 0 = shift-add multiply
//   opa, opb       : unsigned operand magnitudes
//   next_hi/lo     : register contents after the current step
//                    multiply: {next_hi,next_lo} = partial product
//                    divide  : next_hi = remainder, next_lo = quotient
// After WIDTH steps the next_* values hold the final result.
module md_iter_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo
);

  logic [WIDTH-1:0] hi_q, lo_q, opb_q;
  logic [WIDTH:0]   sum, shifted, diff;

  always_comb begin
    // Multiply: add multiplicand when the multiplier LSB is set, then shift right.
    sum     = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opb_q : {WIDTH{1'b0}})};
    // Divide: shift the next dividend bit into the partial remainder and trial-subtract.
    shifted = {hi_q, lo_q[WIDTH-1]};
    diff    = shifted - {1'b0, opb_q};
    if (is_div) begin
      if (!diff[WIDTH]) begin
        next_hi = diff[WIDTH-1:0];
        next_lo = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        next_hi = shifted[WIDTH-1:0];
        next_lo = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      next_hi = sum[WIDTH:1];
      next_lo = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q  <= '0;
      lo_q  <= '0;
      opb_q <= '0;
    end else if (load) begin
      hi_q  <= '0;
      lo_q  <= opa;
      opb_q <= opb;
    end else if (step) begin
      hi_q <= next_hi;
      lo_q <= next_lo;
    end
  end

endmodule

// File: rtl/alu_md_controller.sv
// ALU control decoder plus iterative M-extension multiply/divide controller.
//   clk, reset          : clock, synchronous active-high reset
//   valid_i             : instruction in decode/execute is valid
//   ALUOp, OpR          : main-decoder class, R-type flag
//   Funct7, Funct3      : instruction function fields
//   src_a, src_b        : M-extension operands (rs1, rs2)
//   Operation           : combinational ALU operation select
//   md_busy             : iterative operation in progress (CALC or DONE)
//   md_done             : one-cycle pulse, md_result valid
//   md_result           : M-extension result, held until the next completion
//   stall               : hold the pipeline front-end
// Every M operation takes exactly WIDTH iterations regardless of operands.
module alu_md_controller
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [1:0]       ALUOp,
  input  logic             OpR,
  input  logic [6:0]       Funct7,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [OPW-1:0]   Operation,
  output logic             md_busy,
  output logic             md_done,
  output logic [WIDTH-1:0] md_result,
  output logic             stall
);

  localparam int unsigned CW = $clog2(WIDTH);

  md_state_e        state_q;
  logic [CW-1:0]    cnt_q;
  logic [2:0]       f3_q;
  logic             a_neg_q, b_neg_q, div0_q;
  logic             md_busy_q, md_done_q;
  logic [WIDTH-1:0] md_result_q;

  logic             md_req;
  alu_op_e          op_sel;
  logic             a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] core_hi, core_lo;
  logic [2*WIDTH-1:0] prod_mag, prod_s;
  logic [WIDTH-1:0] mul_res, quot, rem, fixed_res;

  assign md_req = valid_i && (ALUOp == AluOpArith) && OpR && (Funct7 == F7MulDiv);

  // ALU operation decode
  always_comb begin
    op_sel = OpAdd;
    case (ALUOp)
      AluOpMem, AluOpJump: op_sel = OpAdd;
      AluOpBranch:         op_sel = OpEq;
      default: begin
        if (md_req) begin
          op_sel = OpAdd;
        end else begin
          case (Funct3)
            3'b000:  op_sel = (OpR && Funct7 == F7Alt) ? OpSub : OpAdd;
            3'b001:  op_sel = OpSll;
            3'b010:  op_sel = OpSlt;
            3'b100:  op_sel = OpXor;
            3'b101:  op_sel = (Funct7 == F7Alt) ? OpSra : OpSrl;
            3'b110:  op_sel = OpOr;
            3'b111:  op_sel = OpAnd;
            default: op_sel = OpAdd;
          endcase
        end
      end
    endcase
  end

  assign Operation = OPW'(op_sel);

  // Operand sign handling: the core only ever sees magnitudes
  always_comb begin
    a_signed = (Funct3 == F3Mulh) || (Funct3 == F3Mulhsu) ||
               (Funct3 == F3Div)  || (Funct3 == F3Rem);
    b_signed = (Funct3 == F3Mulh) || (Funct3 == F3Div) || (Funct3 == F3Rem);
    a_neg    = a_signed && src_a[WIDTH-1];
    b_neg    = b_signed && src_b[WIDTH-1];
    a_mag    = a_neg ? -src_a : src_a;
    b_mag    = b_neg ? -src_b : src_b;
  end

  md_iter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .load   ((state_q == StIdle) && md_req),
    .step   (state_q == StCalc),
    .is_div (f3_q[2]),
    .opa    (a_mag),
    .opb    (b_mag),
    .next_hi(core_hi),
    .next_lo(core_lo)
  );

  // Result sign correction, applied to the core's post-final-step values.
  // Divide by zero: the core leaves the dividend in the remainder, only the
  // quotient needs forcing. Signed overflow falls out of the magnitude math.
  always_comb begin
    prod_mag  = {core_hi, core_lo};
    prod_s    = (a_neg_q ^ b_neg_q) ? -prod_mag : prod_mag;
    mul_res   = (f3_q == F3Mul) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
    quot      = div0_q ? {WIDTH{1'b1}} : ((a_neg_q ^ b_neg_q) ? -core_lo : core_lo);
    rem       = a_neg_q ? -core_hi : core_hi;
    fixed_res = f3_q[2] ? (f3_q[1] ? rem : quot) : mul_res;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      f3_q        <= F3Mul;
      a_neg_q     <= 1'b0;
      b_neg_q     <= 1'b0;
      div0_q      <= 1'b0;
      md_busy_q   <= 1'b0;
      md_done_q   <= 1'b0;
      md_result_q <= '0;
    end else begin
      md_done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (md_req) begin
            state_q   <= StCalc;
            cnt_q     <= CW'(WIDTH - 1);
            f3_q      <= Funct3;
            a_neg_q   <= a_neg;
            b_neg_q   <= b_neg;
            div0_q    <= (src_b == '0);
            md_busy_q <= 1'b1;
          end
        end
        StCalc: begin
          if (cnt_q == '0) begin
            state_q     <= StDone;
            md_done_q   <= 1'b1;
            md_result_q <= fixed_res;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        StDone: begin
          state_q   <= StIdle;
          md_busy_q <= 1'b0;
        end
        default: begin
          state_q   <= StIdle;
          md_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign md_busy   = md_busy_q;
  assign md_done   = md_done_q;
  assign md_result = md_result_q;
  // DONE releases the stall so the waiting instruction can retire.
  assign stall     = ((state_q == StIdle) && md_req) || (state_q == StCalc);

endmodule

// File: tb/tb_alu_md_controller.sv
// Bench for alu_md_controller (WIDTH=32): directed decode vectors and
// directed M-extension operations checked through a scoreboard queue.
module tb_alu_md_controller;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          valid_i = 1'b0;
  logic [1:0]    ALUOp = 2'b00;
  logic          OpR = 1'b0;
  logic [6:0]    Funct7 = 7'b0;
  logic [2:0]    Funct3 = 3'b0;
  logic [W-1:0]  src_a = '0;
  logic [W-1:0]  src_b = '0;
  logic [3:0]    Operation;
  logic          md_busy, md_done, stall;
  logic [W-1:0]  md_result;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] exp_q[$];
  int          acc_q[$];
  string       name_q[$];

  logic [31:0] mon_exp;
  int          mon_acc;
  string       mon_name;

  alu_md_controller #(
    .WIDTH(W),
    .OPW  (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .valid_i  (valid_i),
    .ALUOp    (ALUOp),
    .OpR      (OpR),
    .Funct7   (Funct7),
    .Funct3   (Funct3),
    .src_a    (src_a),
    .src_b    (src_b),
    .Operation(Operation),
    .md_busy  (md_busy),
    .md_done  (md_done),
    .md_result(md_result),
    .stall    (stall)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Monitor: every completion must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && md_done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_acc  = acc_q.pop_front();
        mon_name = name_q.pop_front();
        chk({mon_name, "_result"}, md_result, mon_exp);
        chk({mon_name, "_latency"}, cyc - mon_acc, W);
        chk({mon_name, "_stall_in_done"}, {31'd0, stall}, 32'd0);
      end
    end
  end

  task automatic dec(input string nm, input logic [1:0] aop, input logic opr,
                     input logic [6:0] f7, input logic [2:0] f3, input logic [3:0] expv);
    @(negedge clk);
    ALUOp = aop; OpR = opr; Funct7 = f7; Funct3 = f3; valid_i = 1'b1;
    #1;
    chk(nm, {28'd0, Operation}, {28'd0, expv});
    chk({nm, "_stall"}, {31'd0, stall}, 32'd0);
  endtask

  // Drives an M request at the current point (caller aligns to negedge).
  task automatic set_req(input string nm, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b);
    ALUOp = 2'b10; OpR = 1'b1; Funct7 = 7'b0000001; Funct3 = f3;
    src_a = a; src_b = b; valid_i = 1'b1;
    #1;
    chk({nm, "_stall_req"}, {31'd0, stall}, 32'd1);
    chk({nm, "_op_add"}, {28'd0, Operation}, 32'd2);
  endtask

  // Waits for completion; hold keeps a new request asserted while busy.
  task automatic wait_done(input string nm, input bit hold);
    int  stalls = 0;
    bit  seen = 1'b0;
    for (int i = 0; i < 3 * W && !seen; i++) begin
      @(negedge clk);
      if (md_done) seen = 1'b1;
      else if (stall) stalls++;
      if (hold && !md_done) begin
        Funct3 = 3'b000; src_a = 32'd1; src_b = 32'd1; valid_i = 1'b1;
      end else begin
        valid_i = 1'b0;
      end
    end
    chk({nm, "_timeout"}, {31'd0, seen}, 32'd1);
    chk({nm, "_stall_cycles"}, stalls, W);
    @(negedge clk);
    chk({nm, "_busy_after"}, {31'd0, md_busy}, 32'd0);
    chk({nm, "_done_pulse"}, {31'd0, md_done}, 32'd0);
  endtask

  task automatic md_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expv, input bit hold);
    @(negedge clk);
    set_req(nm, f3, a, b);
    exp_q.push_back(expv);
    acc_q.push_back(cyc + 1);
    name_q.push_back(nm);
    wait_done(nm, hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, md_busy}, 32'd0);
    chk("rst_done", {31'd0, md_done}, 32'd0);
    chk("rst_result", md_result, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    reset = 1'b0;

    dec("dec_sub",      2'b10, 1'b1, 7'b0100000, 3'b000, 4'b0011);
    dec("dec_add_r",    2'b10, 1'b1, 7'b0000000, 3'b000, 4'b0010);
    dec("dec_addi_alt", 2'b10, 1'b0, 7'b0100000, 3'b000, 4'b0010);
    dec("dec_sra_r",    2'b10, 1'b1, 7'b0100000, 3'b101, 4'b0111);
    dec("dec_srai",     2'b10, 1'b0, 7'b0100000, 3'b101, 4'b0111);
    dec("dec_srl",      2'b10, 1'b1, 7'b0000000, 3'b101, 4'b0101);
    dec("dec_sll",      2'b10, 1'b1, 7'b0000000, 3'b001, 4'b0110);
    dec("dec_slt",      2'b10, 1'b1, 7'b0000000, 3'b010, 4'b1100);
    dec("dec_unmatch",  2'b10, 1'b1, 7'b0000000, 3'b011, 4'b0010);
    dec("dec_xor",      2'b10, 1'b1, 7'b0000000, 3'b100, 4'b0100);
    dec("dec_or",       2'b10, 1'b1, 7'b0000000, 3'b110, 4'b0001);
    dec("dec_and",      2'b10, 1'b0, 7'b0000000, 3'b111, 4'b0000);
    dec("dec_mem",      2'b00, 1'b1, 7'b0100000, 3'b111, 4'b0010);
    dec("dec_branch",   2'b01, 1'b0, 7'b0000000, 3'b001, 4'b1000);
    dec("dec_jump",     2'b11, 1'b0, 7'b0000000, 3'b100, 4'b0010);
    @(negedge clk);
    valid_i = 1'b0;

    md_op("mul_7_m3",     3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
    md_op("mulhu_max",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    md_op("div_ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
    md_op("rem_ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0);
    md_op("divu_zero",    3'b101, 32'd100,      32'd0,        32'hFFFFFFFF, 1'b0);
    md_op("remu_zero",    3'b111, 32'd100,      32'd0,        32'd100,      1'b0);
    md_op("mulh_m2_3",    3'b001, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b0);
    md_op("mulhsu_m1",    3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    md_op("mulh_2p32",    3'b001, 32'h40000000, 32'd4,        32'h00000001, 1'b0);
    md_op("div_m7_2",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b1);
    md_op("rem_m7_2",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0);
    md_op("div_7_m2",     3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0);
    md_op("rem_7_m2",     3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        1'b0);
    md_op("divu_big",     3'b101, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 1'b0);
    md_op("remu_big",     3'b111, 32'hFFFFFFF9, 32'd2,        32'd1,        1'b0);
    md_op("div_zero_s",   3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b0);
    md_op("rem_zero_s",   3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1'b0);

    // Abort a DIV with reset ten edges after acceptance; no completion expected.
    @(negedge clk);
    set_req("div_abort", 3'b100, 32'd100, 32'd7);
    @(negedge clk);
    valid_i = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'd0, md_busy}, 32'd0);
    chk("abort_done", {31'd0, md_done}, 32'd0);
    chk("abort_result", md_result, 32'd0);
    chk("abort_stall_idle", {31'd0, stall}, 32'd0);
    // Request raised while still in reset; accepted on the first edge with reset low.
    set_req("mul_3_4", 3'b000, 32'd3, 32'd4);
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(32'd12);
    acc_q.push_back(cyc + 1);
    name_q.push_back("mul_3_4");
    wait_done("mul_3_4", 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_md_controller.md
ALU_MD_CONTROLLER -- requirements
Module: alu_md_controller

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits (>= 8, even).
REQ-002 Parameter OPW, default 4, width of Operation output.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 valid_i  input  1  instruction in decode/execute is valid this cycle.
REQ-006 ALUOp  input  2  00 LW/SW/AUIPC, 01 branch, 10 R/I-type, 11 JAL/LUI.
REQ-007 OpR  input  1  1 = R-type (Funct7 meaningful), 0 = I-type.
REQ-008 Funct7  input  7  instruction bits 31:25.
REQ-009 Funct3  input  3  instruction bits 14:12.
REQ-010 src_a, src_b  input  WIDTH each  M-extension operands rs1, rs2.
REQ-011 Operation  output  OPW  ALU operation select, combinational.
REQ-012 md_busy  output  1  iterative multiply/divide in progress.
REQ-013 md_done  output  1  one-cycle pulse, md_result valid.
REQ-014 md_result  output  WIDTH  M-extension result.
REQ-015 stall  output  1  hold pipeline front-end.

Function
REQ-016 Operation codes: AND 0000, OR 0001, ADD 0010, SUB 0011, XOR 0100, SRL 0101, SLL 0110, SRA 0111, EQ 1000, SLT 1100; decode is combinational, zero latency.
REQ-017 ALUOp 00 or 11 -> ADD; ALUOp 01 -> EQ; ALUOp 10 decodes Funct3; SUB only when OpR=1 and Funct7=0100000; SRA when Funct3=101 and Funct7=0100000 (either OpR); unmatched -> ADD.
REQ-018 md request = valid_i & ALUOp=10 & OpR=1 & Funct7=0000001; Funct3 selects MUL 000, MULH 001, MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111; Operation = ADD during md request.
REQ-019 FSM states IDLE, CALC, DONE; IDLE->CALC on md request (operands, Funct3 latched); CALC lasts exactly WIDTH cycles (counter WIDTH-1 down to 0); CALC->DONE; DONE->IDLE after one cycle.
REQ-020 Fixed latency: request accepted at edge N, md_done=1 during cycle N+WIDTH+1, for every Funct3 and operand value.
REQ-021 md_busy=1 in CALC and DONE; md_done=1 only in DONE; md_result holds last value until next DONE.
REQ-022 stall = (md request in IDLE) | (state=CALC); stall=0 in DONE, letting the stalled instruction retire.
REQ-023 valid_i / request inputs ignored while not IDLE; no queueing.
REQ-024 Multiply: unsigned shift-add on magnitudes, 2*WIDTH product, sign-correct per op; MUL low half, MULH/MULHSU/MULHU high half.
REQ-025 Divide: restoring, unsigned on magnitudes; quotient sign = sign(a)^sign(b), remainder sign = sign(a).
REQ-026 Divide by zero: quotient all ones, remainder = src_a (both signed and unsigned).
REQ-027 Signed overflow (a = most negative, b = -1): DIV quotient = src_a, REM = 0.

Reset
REQ-028 reset forces state IDLE, counter 0, md_busy 0, md_done 0, md_result 0, stall driven only by combinational request term.
REQ-029 reset during CALC or DONE aborts the operation; no md_done pulse; request accepted on first cycle with reset low.

Structure
REQ-030 Package alu_ctrl_pkg holds ALUOp codes, Operation code enum, M Funct3 codes, FSM state enum.
REQ-031 One sub-module md_iter_core (shift-add / restoring datapath, WIDTH-parametrised); FSM, decode and sign handling stay in alu_md_controller.

Verification (WIDTH=32)
REQ-032 ALUOp=10, OpR=1, Funct3=000, Funct7=0100000 -> Operation=0011 same cycle, stall=0.
REQ-033 MUL 7 x 0xFFFFFFFD accepted at edge N -> md_done in cycle N+33, md_result=0xFFFFFFEB, stall high N..N+32.
REQ-034 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> md_result=0xFFFFFFFE.
REQ-035 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0x00000000.
REQ-036 DIVU 100 / 0 -> 0xFFFFFFFF; REMU 100 / 0 -> 100; latency still 33.
REQ-037 reset asserted at N+10 of a DIV -> next cycle md_busy=0, no md_done; new MUL 3x4 accepted after reset -> 12.
